// File: rtl/rx_uart.sv
// UART receiver. It recovers 8N1 frames (8E1 when RX_UART_PARITY_EN is defined)
// from an asynchronous pin and outputs each byte with a one-cycle valid strobe.
module rx_uart #(
  parameter int TIMER_BITS      = 32,
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       uart_txd_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic [3:0] o_bit_rx
);

  localparam logic [TIMER_BITS-1:0] HALF_LOAD = TIMER_BITS'((CLOCKS_PER_BAUD >> 1) - 1);
  localparam logic [TIMER_BITS-1:0] FULL_LOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_UART_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                state, state_next;
  logic                  sync1, s;
  logic [TIMER_BITS-1:0] cnt, cnt_next;
  logic [7:0]            shreg, shreg_next;
  logic [2:0]            idx, idx_next;
  logic [7:0]            data_q, data_next;
  logic                  valid_q, valid_next;
  logic                  ferr_q, ferr_next;
  logic                  sample;
`ifdef RX_UART_PARITY_EN
  logic                  par_bad, par_bad_next;
  logic                  perr_q, perr_next;
`endif

  // Both synchronizer flops reset high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= uart_txd_in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      idx     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_UART_PARITY_EN
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      shreg   <= shreg_next;
      idx     <= idx_next;
      data_q  <= data_next;
      valid_q <= valid_next;
      ferr_q  <= ferr_next;
`ifdef RX_UART_PARITY_EN
      par_bad <= par_bad_next;
      perr_q  <= perr_next;
`endif
    end
  end

  assign sample = (cnt == '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    idx_next   = idx;
    data_next  = data_q;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef RX_UART_PARITY_EN
    par_bad_next = par_bad;
    perr_next    = 1'b0;
`endif

    // Baud counter runs in every bit-timed state; IDLE overrides the load below.
    if (state != IDLE && state != WAIT_IDLE)
      cnt_next = sample ? FULL_LOAD : cnt - TIMER_BITS'(1);

    case (state)
      IDLE: begin
        if (!s) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (sample) begin
          if (s) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            idx_next   = '0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_next = {s, shreg[7:1]};
          if (idx == 3'd7) begin
`ifdef RX_UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
`ifdef RX_UART_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_bad_next = ^{shreg, s};
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (s) begin
`ifdef RX_UART_PARITY_EN
            if (par_bad) begin
              perr_next = 1'b1;
            end else begin
              data_next  = shreg;
              valid_next = 1'b1;
            end
`else
            data_next  = shreg;
            valid_next = 1'b1;
`endif
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
`ifdef RX_UART_PARITY_EN
            perr_next  = par_bad;
`endif
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_bit_rx = 4'd15;
    case (state)
      START:  o_bit_rx = 4'd0;
      DATA:   o_bit_rx = {1'b0, idx} + 4'd1;
`ifdef RX_UART_PARITY_EN
      PARITY: o_bit_rx = 4'd9;
      STOP:   o_bit_rx = 4'd10;
`else
      STOP:   o_bit_rx = 4'd9;
`endif
      default: o_bit_rx = 4'd15;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
`ifdef RX_UART_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart.sv
// Scoreboard bench for rx_uart: expected pulses are queued as frames are sent
// and matched by a negedge monitor.
module tb_rx_uart;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       uart_txd_in;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic [3:0] o_bit_rx;

  rx_uart #(.TIMER_BITS(32), .CLOCKS_PER_BAUD(CPB)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .uart_txd_in  (uart_txd_in),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_bit_rx     (o_bit_rx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] kind;  // {parity_err, frame_err, valid}
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned valid_times[$];
  int unsigned cycle = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  last_data;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!i_reset && (o_valid || o_frame_err || o_parity_err)) begin
      logic [2:0] kind;
      exp_t e;
      kind = {o_parity_err, o_frame_err, o_valid};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(kind), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(kind), 32'(e.kind));
        check("pulse_data", 32'(o_data), 32'(e.data));
      end
      if (o_valid) valid_times.push_back(cycle);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    uart_txd_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = d[i];
      wait_cycles(CPB);
    end
`ifdef RX_UART_PARITY_EN
    uart_txd_in = par_v;
    wait_cycles(CPB);
`endif
    uart_txd_in = stop_v;
    wait_cycles(CPB);
    uart_txd_in = 1'b1;
  endtask

  task automatic expect_good(input logic [7:0] d);
    exp_q.push_back('{kind: 3'b001, data: d});
    last_data = d;
  endtask

  initial begin
    logic [7:0] rst_byte;
    i_reset     = 1'b1;
    uart_txd_in = 1'b1;
    last_data   = 8'h00;
    wait_cycles(3);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_perr", 32'(o_parity_err), 32'd0);
    check("rst_bit_rx", 32'(o_bit_rx), 32'd15);
    i_reset = 1'b0;
    wait_cycles(5);

    // Basic frame
    expect_good(8'h55);
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_cycles(20);
    check("idle_after_55", 32'(o_bit_rx), 32'd15);

    // False start: 5 low cycles is shorter than half a bit
    uart_txd_in = 1'b0;
    wait_cycles(5);
    uart_txd_in = 1'b1;
    wait_cycles(30);
    check("false_start_bit_rx", 32'(o_bit_rx), 32'd15);
    check("false_start_data", 32'(o_data), 32'h55);

    // Framing error, then recovery
    exp_q.push_back('{kind: 3'b010, data: last_data});
    send_frame(8'hA3, 1'b0, ^8'hA3);
    wait_cycles(20);
    check("ferr_data_kept", 32'(o_data), 32'h55);
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    wait_cycles(20);

    // Back-to-back frames with single stop bits
    valid_times.delete();
    expect_good(8'h00);
    expect_good(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    wait_cycles(20);
    check("b2b_count", 32'(valid_times.size()), 32'd2);
    if (valid_times.size() == 2)
      check("b2b_gap", valid_times[1] - valid_times[0], 32'(10 * CPB));

`ifdef RX_UART_PARITY_EN
    exp_q.push_back('{kind: 3'b100, data: last_data});
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cycles(20);
    check("perr_data_kept", 32'(o_data), 32'hFF);
    expect_good(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cycles(20);
`endif

    // Reset during data bit 4 aborts the frame silently
    rst_byte    = 8'hE5;
    uart_txd_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_txd_in = rst_byte[i];
      wait_cycles(CPB);
    end
    uart_txd_in = rst_byte[4];
    wait_cycles(CPB / 2);
    check("pre_reset_bit_rx", 32'(o_bit_rx), 32'd5);
    i_reset     = 1'b1;
    uart_txd_in = 1'b1;
    wait_cycles(1);
    i_reset     = 1'b0;
    last_data   = 8'h00;
    check("abort_bit_rx", 32'(o_bit_rx), 32'd15);
    check("abort_data", 32'(o_data), 32'h00);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_ferr", 32'(o_frame_err), 32'd0);
    wait_cycles(12 * CPB);
    check("abort_idle", 32'(o_bit_rx), 32'd15);

    expect_good(8'h96);
    send_frame(8'h96, 1'b1, ^8'h96);
    wait_cycles(20);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_uart.md
# rx_uart

UART receiver, the counterpart of the board's transmit path: it recovers 8N1 frames from the asynchronous `uart_txd_in` pin and presents each byte as a parallel word with a one-cycle valid strobe. It sits between the board's USB-UART bridge pin and the command/loopback logic. The bit clock is derived from a programmable clocks-per-baud divider.

## Interface
- `TIMER_BITS`, 32: width of the baud counter.
- `CLOCKS_PER_BAUD`, 868: clk cycles per bit (100 MHz / 115200). Must be ≥ 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `uart_txd_in`  in  1  asynchronous serial line; idles high.
- `o_data`  out  8  last received byte, LSB first on the wire; held until the next good frame.
- `o_valid`  out  1  one-cycle pulse: `o_data` updated with a good frame.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `o_parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 unless `RX_UART_PARITY_EN`.
- `o_bit_rx`  out  4  frame position: 15 idle, 0 start, 1–8 data, 9 stop (parity build: 9 parity, 10 stop).

## Operation
- Input path: 2-flop synchronizer, both flops reset to 1. All decisions use the synchronized value `s`.
- States: IDLE, START, DATA, PARITY (parity build only), STOP, WAIT_IDLE.
- IDLE: the first cycle with `s`=0 (cycle E) loads the counter with `(CLOCKS_PER_BAUD>>1)-1` and moves to START.
- Counter decrements every cycle outside IDLE and WAIT_IDLE. A "sample" happens in the cycle the counter reads 0; that cycle also reloads it with `CLOCKS_PER_BAUD-1`.
- START sample: `s`=1 is a false start; return to IDLE with no output pulse. `s`=0 goes to DATA with bit index 0.
- DATA sample: shift `s` into bit 7 of the shift register (right shift, LSB first). After the 8th sample, go to PARITY or STOP.
- PARITY sample: even parity. XOR of the 8 data bits and the parity bit must be 0; otherwise pulse `o_parity_err` alongside the STOP outcome.
- STOP sample, `s`=1: load `o_data`, pulse `o_valid` (suppressed if parity failed), return to IDLE.
- STOP sample, `s`=0: pulse `o_frame_err`; `o_data` unchanged; go to WAIT_IDLE.
- WAIT_IDLE: remain until `s`=1, then go to IDLE. A held-low break yields exactly one `o_frame_err`.
- `o_bit_rx` tracks state: 15 in IDLE and WAIT_IDLE, 0 in START, index+1 in DATA, 9 or 10 in PARITY/STOP.

## Timing
- Reset values: `o_data`=0x00, `o_valid`=0, `o_frame_err`=0, `o_parity_err`=0, `o_bit_rx`=15, state IDLE, counter 0.
- Reset mid-frame aborts the frame; no pulse is issued for it.
- `s` lags the pin by 2 cycles. Let H = `(CLOCKS_PER_BAUD>>1)`.
- Start sample at cycle E+H.
- Data bit n (0..7) sampled at E+H+(n+1)·CLOCKS_PER_BAUD.
- Stop sample at E+H+9·CPB (parity build: parity at +9·CPB, stop at +10·CPB).
- `o_valid`, `o_frame_err` and `o_parity_err` are registered and high in the cycle after the stop sample, for exactly 1 cycle.
- Back-to-back frames: IDLE is re-entered in the cycle after a good stop sample, so a start edge half a bit after that sample is caught. One stop bit is sufficient.
- No receive-side flow control: the consumer must take `o_data` before the next `o_valid`.

## Configuration
- `RX_UART_PARITY_EN` defined: frame is 8E1; the PARITY state and `o_parity_err` logic are compiled in; `o_bit_rx` reaches 10.
- Not defined: frame is 8N1; `o_parity_err` is constant 0; no PARITY state exists.

## Test plan
- `CLOCKS_PER_BAUD`=16, send 0x55 8N1 → one `o_valid` pulse, `o_data`=0x55, no errors, `o_bit_rx` returns to 15.
- Pin low for 5 cycles, then high → false start: no pulses, state IDLE, `o_data` unchanged.
- Send 0xA3 with stop bit 0, then line high → one `o_frame_err` pulse, no `o_valid`, `o_data` still the previous value; the next frame 0x3C is received correctly.
- Back-to-back 0x00 then 0xFF with single stop bits → two `o_valid` pulses exactly 10·16=160 cycles apart, carrying 0x00 then 0xFF.
- Assert `i_reset` during data bit 4 → next cycle `o_bit_rx`=15 and all outputs at reset values; no pulse for the aborted frame.
- `RX_UART_PARITY_EN`, send 0x07 with parity bit 0 → `o_parity_err` pulse, no `o_valid`. Resend with parity 1 → `o_valid`, `o_data`=0x07.
